// File: rtl/cci_line_reader.sv
// CCI-P channel-0 read-request engine: streams a contiguous run of cache lines
// into the line buffer, with a credit count that keeps the buffer from overflowing.
module cci_line_reader #(
    parameter int ADDR_WIDTH = 42,
    parameter int BUF_LINES  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [63:0]           length_bytes,
    input  logic [ADDR_WIDTH-1:0] base_cl_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_req_valid,
    output logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic [15:0]           rd_req_mdata,
    input  logic                  c0_almost_full,
    input  logic                  rd_rsp_valid,
    input  logic [511:0]          rd_rsp_data,
    output logic                  buf_wr_en,
    output logic [511:0]          buf_wr_data,
    input  logic                  buf_line_consumed
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] CREDIT_MAX = 8'(BUF_LINES);

    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [58:0]           num_lines_r;
    logic [58:0]           num_lines_s;
    logic [58:0]           issued_r;
    logic [58:0]           issued_next_s;
    logic [58:0]           received_r;
    logic [58:0]           received_next_s;
    logic [7:0]            credits_r;
    logic [7:0]            credits_s;
    logic [64:0]           len_round_s;
    logic                  issue_s;
    logic                  rsp_take_s;

    // Line count, request/response qualification and next counter values.
    always_comb begin
        // One spare bit keeps the +63 rounding from wrapping at the top of the range.
        len_round_s     = {1'b0, length_bytes} + 65'd63;
        num_lines_s     = len_round_s[64:6];
        issue_s         = (state_r == ST_ISSUE) && !c0_almost_full &&
                          (credits_r != 8'd0) && (issued_r < num_lines_r);
        rsp_take_s      = ((state_r == ST_ISSUE) || (state_r == ST_DRAIN)) &&
                          rd_rsp_valid && (received_r < num_lines_r);
        issued_next_s   = issued_r + {58'd0, issue_s};
        received_next_s = received_r + {58'd0, rsp_take_s};
    end

    // Credit update: an issue spends one, a consumed line returns one, capped at depth.
    always_comb begin
        credits_s = credits_r;
        if (issue_s && !buf_line_consumed) begin
            credits_s = credits_r - 8'd1;
        end else if (!issue_s && buf_line_consumed && (credits_r < CREDIT_MAX)) begin
            credits_s = credits_r + 8'd1;
        end else begin
            credits_s = credits_r;
        end
    end

    // Next-state logic; completion is decided on the edge that counts the last response.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_ISSUE;
                else       state_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (issued_next_s == num_lines_r) begin
                    if (received_next_s == num_lines_r) state_s = ST_DONE;
                    else                                state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (received_next_s == num_lines_r) state_s = ST_DONE;
                else                                state_s = ST_DRAIN;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, run counters, credits and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            base_r       <= '0;
            num_lines_r  <= 59'd0;
            issued_r     <= 59'd0;
            received_r   <= 59'd0;
            credits_r    <= CREDIT_MAX;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_req_valid <= 1'b0;
            rd_req_addr  <= '0;
            rd_req_mdata <= 16'd0;
            buf_wr_en    <= 1'b0;
            buf_wr_data  <= 512'd0;
        end else begin
            state_r   <= state_s;
            credits_r <= credits_s;
            if ((state_r == ST_IDLE) && start) begin
                base_r      <= base_cl_addr;
                num_lines_r <= num_lines_s;
                issued_r    <= 59'd0;
                received_r  <= 59'd0;
            end else begin
                issued_r    <= issued_next_s;
                received_r  <= received_next_s;
            end
            busy         <= (state_s != ST_IDLE);
            done         <= (state_s == ST_DONE);
            rd_req_valid <= issue_s;
            if (issue_s) begin
                rd_req_addr  <= base_r + ADDR_WIDTH'(issued_r);
                rd_req_mdata <= issued_r[15:0];
            end
            buf_wr_en <= rsp_take_s;
            if (rsp_take_s) begin
                buf_wr_data <= rd_rsp_data;
            end
        end
    end

endmodule
